// File: rtl/nts_ip_pkg.sv
// nts_ip_pkg
// Shared protocol constants for the NTS Ethernet/IPv4/UDP header path, plus
// the record of latched transmit fields and a small length helper.
// Ports: none (package).
package nts_ip_pkg;

  localparam logic [15:0] E_TYPE_IPV4  = 16'h0800;
  localparam logic [3:0]  IP_V4        = 4'h4;
  localparam logic [3:0]  IHL_MIN      = 4'd5;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;

  localparam logic [7:0]  ETH_HDR_LEN  = 8'd14;
  localparam logic [7:0]  IP_HDR_LEN   = 8'd20;
  localparam logic [7:0]  UDP_HDR_LEN  = 8'd8;

  // Don't-fragment flag with a zero fragment offset.
  localparam logic [15:0] IP_FLAGS_DF  = 16'h4000;

  // Checksum input words run 0..9; output words run 0..5.
  localparam logic [3:0]  CSUM_LAST_IDX = 4'd9;
  localparam logic [2:0]  HDR_LAST_WORD = 3'd5;

  typedef struct packed {
    logic [47:0] eth_dst;
    logic [47:0] eth_src;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] ip_id;
    logic [15:0] udp_src;
    logic [15:0] udp_dst;
    logic [15:0] total_len;
    logic [15:0] udp_len;
  } nts_tx_fields_t;

  // Payload plus header bytes, kept at 17 bits so overflow stays visible.
  function automatic logic [16:0] len_add(input logic [15:0] payload,
                                          input logic [7:0]  hdr_len);
    return {1'b0, payload} + {9'd0, hdr_len};
  endfunction

endpackage

// File: rtl/nts_ip_csum16.sv
// nts_ip_csum16
// Running 16-bit one's-complement sum with a 17-bit accumulator. The carry
// out of each add is held in bit 16 and folded back into the next add, so the
// accumulator never loses a carry. Usable for both building and checking.
// Ports:
//   i_clk, i_areset : clock, asynchronous active-high reset
//   i_clear         : synchronous clear of the accumulator (wins over add)
//   i_add_en        : add i_data this cycle
//   i_data          : 16-bit word to add
//   o_sum           : folded 16-bit sum (not inverted)
module nts_ip_csum16 (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_clear,
  input  logic        i_add_en,
  input  logic [15:0] i_data,
  output logic [15:0] o_sum
);

  logic [16:0] r_acc;
  logic [16:0] w_fold;

  // Accumulate with end-around carry: the previous carry (bit 16) is added in
  // alongside the new word. The worst case 0xFFFF + 0xFFFF + 1 fits 17 bits.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_add_en) begin
      r_acc <= {1'b0, r_acc[15:0]} + {1'b0, i_data} + {16'd0, r_acc[16]};
    end
  end

  // Fold twice: the first fold can itself carry out when the low half is
  // all ones.
  always_comb begin
    w_fold = {1'b0, r_acc[15:0]} + {16'd0, r_acc[16]};
    o_sum  = w_fold[15:0] + {15'd0, w_fold[16]};
  end

endmodule

// File: rtl/nts_ip_tx_header.sv
// nts_ip_tx_header
// Builds a 42-byte Ethernet + IPv4 + UDP header and streams it as six
// big-endian 64-bit words with a valid/ready handshake. The IPv4 header
// checksum is computed one 16-bit word per cycle before emission, so the first
// word always appears 12 cycles after the start is accepted.
// Ports:
//   i_clk, i_areset        : clock, asynchronous active-high reset
//   i_clear                : synchronous abort back to idle (beats i_start)
//   i_start                : latch all header fields and begin (idle only)
//   i_eth_*, i_ip_*, i_udp_*, i_payload_length : header field inputs
//   i_ready                : downstream accepts the current word
//   o_valid, o_data        : header word stream, first octet in [63:56]
//   o_bytes_valid, o_last  : left-aligned valid byte count, final word flag
//   o_busy                 : not idle
//   o_done                 : pulse after the final word is accepted
//   o_error                : pulse when a start is rejected (payload too big)
module nts_ip_tx_header
  import nts_ip_pkg::*;
#(
  parameter logic [7:0] IP_TTL = 8'd64
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_clear,
  input  logic        i_start,
  input  logic [47:0] i_eth_dst,
  input  logic [47:0] i_eth_src,
  input  logic [31:0] i_ip_src,
  input  logic [31:0] i_ip_dst,
  input  logic [15:0] i_ip_id,
  input  logic [15:0] i_udp_src,
  input  logic [15:0] i_udp_dst,
  input  logic [15:0] i_payload_length,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic [3:0]  o_bytes_valid,
  output logic        o_last,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CSUM = 2'd1;
  localparam logic [1:0] ST_FOLD = 2'd2;
  localparam logic [1:0] ST_EMIT = 2'd3;

  logic [1:0]     r_state;
  logic [3:0]     r_csum_idx;
  logic [2:0]     r_word_idx;
  nts_tx_fields_t r_fields;
  logic [15:0]    r_ip_csum;
  logic           r_done;
  logic           r_error;

  logic [16:0]    w_total_len;
  logic [16:0]    w_udp_len;
  logic           w_oversize;
  logic           w_accept;
  logic           w_csum_clear;
  logic           w_csum_add;
  logic [15:0]    w_csum_word;
  logic [15:0]    w_csum_sum;
  logic [63:0]    w_data;

  // A payload above 65507 pushes total_length past 16 bits, so bit 16 of the
  // 17-bit sum is exactly the rejection condition.
  assign w_total_len = len_add(i_payload_length, IP_HDR_LEN + UDP_HDR_LEN);
  assign w_udp_len   = len_add(i_payload_length, UDP_HDR_LEN);
  assign w_oversize  = w_total_len[16] | w_udp_len[16];
  assign w_accept    = (r_state == ST_IDLE) & i_start & ~i_clear & ~w_oversize;

  // Starting a new frame also clears the accumulator so no stale sum leaks in.
  assign w_csum_clear = i_clear | w_accept;
  assign w_csum_add   = (r_state == ST_CSUM) & ~i_clear;

  nts_ip_csum16 u_csum (
    .i_clk    (i_clk),
    .i_areset (i_areset),
    .i_clear  (w_csum_clear),
    .i_add_en (w_csum_add),
    .i_data   (w_csum_word),
    .o_sum    (w_csum_sum)
  );

  // IPv4 header words in wire order; index 5 is the checksum field itself,
  // which contributes zero.
  always_comb begin
    w_csum_word = 16'h0000;
    case (r_csum_idx)
      4'd0: w_csum_word = {IP_V4, IHL_MIN, 8'h00};
      4'd1: w_csum_word = r_fields.total_len;
      4'd2: w_csum_word = r_fields.ip_id;
      4'd3: w_csum_word = IP_FLAGS_DF;
      4'd4: w_csum_word = {IP_TTL, IP_PROTO_UDP};
      4'd6: w_csum_word = r_fields.ip_src[31:16];
      4'd7: w_csum_word = r_fields.ip_src[15:0];
      4'd8: w_csum_word = r_fields.ip_dst[31:16];
      4'd9: w_csum_word = r_fields.ip_dst[15:0];
      default: w_csum_word = 16'h0000;
    endcase
  end

  // Main sequencer: idle -> ten checksum adds -> fold/invert -> six words.
  // Clear overrides everything; done/error are single-cycle pulses.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_state    <= ST_IDLE;
      r_csum_idx <= '0;
      r_word_idx <= '0;
      r_fields   <= '0;
      r_ip_csum  <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (i_clear) begin
        r_state    <= ST_IDLE;
        r_csum_idx <= '0;
        r_word_idx <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start && w_oversize) begin
              r_error <= 1'b1;
            end else if (w_accept) begin
              r_fields <= '{eth_dst:   i_eth_dst,
                            eth_src:   i_eth_src,
                            ip_src:    i_ip_src,
                            ip_dst:    i_ip_dst,
                            ip_id:     i_ip_id,
                            udp_src:   i_udp_src,
                            udp_dst:   i_udp_dst,
                            total_len: w_total_len[15:0],
                            udp_len:   w_udp_len[15:0]};
              r_csum_idx <= '0;
              r_state    <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (r_csum_idx == CSUM_LAST_IDX) begin
              r_csum_idx <= '0;
              r_state    <= ST_FOLD;
            end else begin
              r_csum_idx <= r_csum_idx + 4'd1;
            end
          end
          ST_FOLD: begin
            r_ip_csum  <= ~w_csum_sum;
            r_word_idx <= '0;
            r_state    <= ST_EMIT;
          end
          ST_EMIT: begin
            if (i_ready) begin
              if (r_word_idx == HDR_LAST_WORD) begin
                r_word_idx <= '0;
                r_done     <= 1'b1;
                r_state    <= ST_IDLE;
              end else begin
                r_word_idx <= r_word_idx + 3'd1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Output word selection; everything reads as zero outside EMIT so the bus
  // is quiet whenever o_valid is low.
  always_comb begin
    w_data = 64'd0;
    if (r_state == ST_EMIT) begin
      case (r_word_idx)
        3'd0: w_data = {r_fields.eth_dst, r_fields.eth_src[47:32]};
        3'd1: w_data = {r_fields.eth_src[31:0], E_TYPE_IPV4,
                        IP_V4, IHL_MIN, 8'h00};
        3'd2: w_data = {r_fields.total_len, r_fields.ip_id, IP_FLAGS_DF,
                        IP_TTL, IP_PROTO_UDP};
        3'd3: w_data = {r_ip_csum, r_fields.ip_src, r_fields.ip_dst[31:16]};
        3'd4: w_data = {r_fields.ip_dst[15:0], r_fields.udp_src,
                        r_fields.udp_dst, r_fields.udp_len};
        default: w_data = 64'd0;
      endcase
    end
  end

  assign o_valid       = (r_state == ST_EMIT);
  assign o_data        = w_data;
  assign o_last        = o_valid & (r_word_idx == HDR_LAST_WORD);
  assign o_bytes_valid = !o_valid ? 4'd0 : (o_last ? 4'd2 : 4'd8);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: doc/nts_ip_tx_header.md
NTS_IP_TX_HEADER -- requirements
Module: nts_ip_tx_header

Interface
REQ-001 SHALL have parameter IP_TTL, default 8'd64, the IPv4 time-to-live inserted in every header.
REQ-002 SHALL have ports, clock and reset first:
- i_clk, input, 1: clock.
- i_areset, input, 1: asynchronous, active-high reset.
- i_clear, input, 1: synchronous abort.
- i_start, input, 1: start header build.
- i_eth_dst, input, 48: Ethernet destination address.
- i_eth_src, input, 48: Ethernet source address.
- i_ip_src, input, 32: IPv4 source address.
- i_ip_dst, input, 32: IPv4 destination address.
- i_ip_id, input, 16: IPv4 identification.
- i_udp_src, input, 16: UDP source port.
- i_udp_dst, input, 16: UDP destination port.
- i_payload_length, input, 16: UDP payload length in bytes.
- i_ready, input, 1: downstream accepts the current word.
- o_valid, output, 1: o_data valid.
- o_data, output, 64: header word, big-endian, first octet in [63:56].
- o_bytes_valid, output, 4: valid bytes in o_data, left-aligned.
- o_last, output, 1: final header word.
- o_busy, output, 1: block not idle.
- o_done, output, 1: one-cycle pulse after the last word is accepted.
- o_error, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-003 SHALL implement states IDLE, CSUM, FOLD and EMIT; o_busy SHALL be 1 in every state except IDLE.
REQ-004 In IDLE, i_start SHALL latch all i_* fields and enter CSUM; i_start outside IDLE SHALL be ignored.
REQ-005 SHALL compute udp_length = 8 + payload and total_length = 28 + payload in 17 bits.
REQ-006 If payload > 65507, start SHALL be rejected: o_error pulses the next cycle and the state stays IDLE.
REQ-007 CSUM SHALL add one 16-bit IPv4 header word per cycle, 10 cycles total, checksum field taken as 0.
- Addition is one's-complement with a 17-bit accumulator and end-around carry.
REQ-008 FOLD SHALL take 1 cycle, fold any residual carry and invert the result to give ip_csum.
REQ-009 Latency SHALL be fixed: start accepted at cycle T gives o_valid = 1 at T+12.
REQ-010 EMIT SHALL output 6 words:
- W0 = eth_dst, eth_src[47:32]
- W1 = eth_src[31:0], 16'h0800, 16'h4500
- W2 = total_length, ip_id, 16'h4000 (DF set), IP_TTL, 8'h11
- W3 = ip_csum, ip_src, ip_dst[31:16]
- W4 = ip_dst[15:0], udp_src, udp_dst, udp_length
- W5 = 16'h0000 (UDP checksum not used), 48'h0
REQ-011 o_bytes_valid SHALL be 8 for W0-W4 and 2 for W5; o_last SHALL be 1 only with W5.
REQ-012 A word SHALL advance only when o_valid and i_ready are both 1.
- While o_valid = 1 and i_ready = 0, o_data, o_bytes_valid and o_last SHALL hold steady.
- With i_ready held at 1, one word SHALL be output per cycle.
REQ-013 After the W5 handshake: o_valid = 0 and o_done = 1 on the next cycle, then IDLE.
- A new i_start is accepted in that same cycle.
REQ-014 i_clear SHALL force IDLE and clear o_valid, o_last and the accumulator on the next edge, in any state.
- i_clear has priority over i_start.
REQ-015 When o_valid = 0, o_data, o_bytes_valid and o_last SHALL be 0.

Reset
REQ-016 i_areset SHALL immediately force IDLE, with every output 0 and all latched fields and the accumulator cleared.
REQ-017 Reset mid-frame SHALL drop the frame; no partial word SHALL be output after release.

Structure
REQ-018 The shared package/include nts_ip_pkg SHALL hold E_TYPE_IPV4 16'h0800, IP_V4 4'h4, IHL_MIN 4'd5, IP_PROTO_UDP 8'h11 and the header length constants 14, 20 and 8.
REQ-019 The one's-complement accumulator SHALL be the sub-module nts_ip_csum16 (clear, add-enable, 16-bit in, 16-bit folded sum).
- The same sub-module is reusable for receive-side checks.

Verification
REQ-020 Start with src c0a80001, dst c0a800c7, id 0, payload 87 ->
- W2 = 0073_0000_4000_4011
- W3 = b861_c0a8_0001_c0a8
- W4 = 00c7_<src>_<dst>_005f
REQ-021 i_ready = 1 throughout -> first o_valid at T+12, 6 consecutive words, o_last only on W5, o_done at the next cycle.
REQ-022 i_ready toggled 1/0 randomly -> exactly 6 handshakes, data stable during stalls, word order unchanged.
REQ-023 Payload 65507 -> total_length ffff and accepted; payload 65508 -> o_error pulse, o_busy stays 0, no o_valid.
REQ-024 i_clear during W3 stall, then start again -> no further words from the old frame; the new frame is correct from W0.
REQ-025 i_areset during CSUM -> all outputs 0 at once; the next start after release gives a correct checksum.
